// File: rtl/adc_frontend_if.sv
// Serial bus to the four-converter ADC array: a shared chip select and two 2-bit data lanes.
// The ADC serial clock is clk_sys itself, forwarded outside this bus.
interface adc_frontend_if;
  logic       ad_cs_n;
  logic [1:0] ad_sdata_a;   // [1] vout, [0] iout
  logic [1:0] ad_sdata_b;   // [1] vcap, [0] icap

  modport master (
    output ad_cs_n,
    input  ad_sdata_a,
    input  ad_sdata_b
  );

  modport slave (
    input  ad_cs_n,
    output ad_sdata_a,
    output ad_sdata_b
  );
endinterface

// File: rtl/adc_frontend.sv
// Frame sequencer for four serial 12-bit ADCs: chip select, MSB-first capture, sample
// registers, icap peak tracking and a saturating frame counter.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no frame in progress; enable starts a frame on the next clock
//   ST_CONV  | ad_cs_n low, frame cycles 0..13, serial bits are captured
//   ST_QUIET | ad_cs_n high, frame cycles 14..PERIOD-1, sample is published
module adc_frontend #(
  parameter int PERIOD    = 16,
  parameter int CAP_FIRST = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  adc_frontend_if.master       adc,
  input  logic                 clear_peak,
  output logic [11:0]          vcap,
  output logic [11:0]          icap,
  output logic [11:0]          vout,
  output logic [11:0]          iout,
  output logic                 sample_valid,
  output logic [11:0]          icap_peak,
  output logic [15:0]          sample_count,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_QUIET = 2'd2;

  localparam logic [4:0] FC_CONV_END = 5'd13;
  localparam logic [4:0] FC_LAST     = 5'(PERIOD - 1);
  localparam logic [4:0] FC_CAP_LO   = 5'(CAP_FIRST);
  localparam logic [4:0] FC_CAP_HI   = 5'(CAP_FIRST + 11);
  localparam logic [4:0] FC_LOAD     = 5'(CAP_FIRST + 12);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [4:0]  fc;
  logic [4:0]  fc_nxt;
  logic        cs_n_q;
  logic        capture;
  logic        load;
  logic [11:0] sh_vcap;
  logic [11:0] sh_icap;
  logic [11:0] sh_vout;
  logic [11:0] sh_iout;

  // Enable is only looked at in IDLE and on the last QUIET cycle, so a frame
  // once started always runs to completion.
  always_comb begin
    state_nxt = state;
    fc_nxt    = fc;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_CONV;
          fc_nxt    = 5'd0;
        end
      end
      ST_CONV: begin
        fc_nxt = fc + 5'd1;
        if (fc == FC_CONV_END) begin
          state_nxt = ST_QUIET;
        end
      end
      ST_QUIET: begin
        if (fc == FC_LAST) begin
          fc_nxt    = 5'd0;
          state_nxt = enable ? ST_CONV : ST_IDLE;
        end else begin
          fc_nxt = fc + 5'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        fc_nxt    = 5'd0;
      end
    endcase
  end

  assign capture = (state == ST_CONV) && (fc >= FC_CAP_LO) && (fc <= FC_CAP_HI);
  assign load    = (state != ST_IDLE) && (fc == FC_LOAD);
  assign busy    = (state != ST_IDLE);

  assign adc.ad_cs_n = cs_n_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      fc     <= 5'd0;
      cs_n_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      fc     <= fc_nxt;
      cs_n_q <= (state_nxt != ST_CONV);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_vcap <= 12'd0;
      sh_icap <= 12'd0;
      sh_vout <= 12'd0;
      sh_iout <= 12'd0;
    end else if (capture) begin
      sh_vout <= {sh_vout[10:0], adc.ad_sdata_a[1]};
      sh_iout <= {sh_iout[10:0], adc.ad_sdata_a[0]};
      sh_vcap <= {sh_vcap[10:0], adc.ad_sdata_b[1]};
      sh_icap <= {sh_icap[10:0], adc.ad_sdata_b[0]};
    end
  end

  // All four outputs move on the same edge, one clock after the last bit lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcap         <= 12'd0;
      icap         <= 12'd0;
      vout         <= 12'd0;
      iout         <= 12'd0;
      sample_valid <= 1'b0;
      sample_count <= 16'd0;
    end else begin
      sample_valid <= load;
      if (load) begin
        vcap <= sh_vcap;
        icap <= sh_icap;
        vout <= sh_vout;
        iout <= sh_iout;
        if (sample_count != 16'hFFFF) begin
          sample_count <= sample_count + 16'd1;
        end
      end
    end
  end

  // A clear landing with a new sample restarts the peak from that sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icap_peak <= 12'd0;
    end else if (clear_peak) begin
      icap_peak <= load ? sh_icap : 12'd0;
    end else if (load && (sh_icap > icap_peak)) begin
      icap_peak <= sh_icap;
    end
  end

endmodule
